tt_checkpoint_ctrl: RTL and testbench

Manages speculative snapshots of the register translation table for branch recovery.
- Captures the full data and status mapping when a branch is renamed, and tracks it in an age-ordered circular buffer.
- Frees the snapshot when the branch resolves correctly.
- On a mispredict, drives a one-cycle restore of that snapshot and squashes all younger snapshots.
- Sits between rename/decode (allocate), the branch unit (resolve) and the translation table (restore port).

---
 rtl/tt_checkpoint_ctrl.sv | 127 ++++++++++++
 tb/tb_tt_checkpoint_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_checkpoint_ctrl.sv
// Speculative checkpoint buffer for the register translation table: snapshots the
// mapping at branch rename, frees it on correct resolve, restores it on mispredict.
module tt_checkpoint_ctrl #(
    parameter  int unsigned NUM_D_REG = 64,
    parameter  int unsigned NUM_S_REG = 16,
    parameter  int unsigned NUM_CKPT  = 4,
    localparam int unsigned DW        = $clog2(NUM_D_REG),
    localparam int unsigned SW        = $clog2(NUM_S_REG),
    localparam int unsigned TW        = $clog2(NUM_CKPT),
    localparam int unsigned RDW       = 16 * DW
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            alloc_req,
    input  logic [RDW-1:0]  snap_d,
    input  logic [SW-1:0]   snap_s,
    output logic            alloc_gnt,
    output logic [TW-1:0]   alloc_tag,
    output logic            stall,
    input  logic            resolve_valid,
    input  logic [TW-1:0]   resolve_tag,
    input  logic            resolve_mispredict,
    output logic            restore,
    output logic [RDW-1:0]  restore_d,
    output logic [SW-1:0]   restore_s,
    output logic [TW:0]     occupancy,
    output logic            full,
    output logic            empty
);

    localparam int unsigned PW = TW + 1;

    logic [PW-1:0]       head_q, tail_q, head_n, tail_n;
    logic [NUM_CKPT-1:0] live_q, done_q, live_n, done_n;
    logic [NUM_CKPT-1:0] squash;
    logic [RDW-1:0]      ckpt_d_q [NUM_CKPT];
    logic [SW-1:0]       ckpt_s_q [NUM_CKPT];

    logic [TW-1:0] head_idx, tail_idx, misp_age;
    logic          misp_valid, good_valid, retire;

    // Occupancy and flags from the wrap-bit pointers
    always_comb begin
        head_idx  = head_q[TW-1:0];
        tail_idx  = tail_q[TW-1:0];
        occupancy = tail_q - head_q;
        full      = (occupancy == PW'(NUM_CKPT));
        empty     = (occupancy == PW'(0));
    end

    // Event decode; a mispredict of the head slot blocks its retire
    always_comb begin
        misp_valid = resolve_valid & resolve_mispredict & live_q[resolve_tag];
        good_valid = resolve_valid & ~resolve_mispredict & live_q[resolve_tag];
        retire     = live_q[head_idx] & done_q[head_idx]
                   & ~(misp_valid & (resolve_tag == head_idx));
        alloc_gnt  = alloc_req & ~full & ~misp_valid;
        alloc_tag  = tail_idx;
        stall      = alloc_req & ~alloc_gnt;
        misp_age   = TW'(resolve_tag - head_idx);
    end

    // Slots at or younger than the mispredicted branch are squashed
    always_comb begin
        squash = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            squash[i] = misp_valid & (TW'(TW'(i) - head_idx) >= misp_age);
        end
    end

    // Next pointer and slot-status state
    always_comb begin
        live_n = live_q;
        done_n = done_q;
        head_n = head_q;
        tail_n = tail_q;
        if (good_valid) begin
            done_n[resolve_tag] = 1'b1;
        end
        if (retire) begin
            live_n[head_idx] = 1'b0;
            done_n[head_idx] = 1'b0;
            head_n           = head_q + PW'(1);
        end
        if (misp_valid) begin
            live_n = live_n & ~squash;
            done_n = done_n & ~squash;
            tail_n = head_q + PW'(misp_age);
        end
        if (alloc_gnt) begin
            live_n[tail_idx] = 1'b1;
            done_n[tail_idx] = 1'b0;
            tail_n           = tail_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            live_q    <= '0;
            done_q    <= '0;
            restore   <= 1'b0;
            restore_d <= '0;
            restore_s <= '0;
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            live_q  <= live_n;
            done_q  <= done_n;
            restore <= misp_valid;
            if (misp_valid) begin
                restore_d <= ckpt_d_q[resolve_tag];
                restore_s <= ckpt_s_q[resolve_tag];
            end
        end
    end

    // Snapshot storage carries no reset; a slot is always written before it is live
    always_ff @(posedge clk) begin
        if (alloc_gnt) begin
            ckpt_d_q[tail_idx] <= snap_d;
            ckpt_s_q[tail_idx] <= snap_s;
        end
    end

endmodule

// File: tb/tb_tt_checkpoint_ctrl.sv
// Directed bench for tt_checkpoint_ctrl: allocation, full/wrap, retire ordering,
// mispredict restore/squash, and reset cancelling a pending restore.
module tb_tt_checkpoint_ctrl;

    localparam int unsigned DW  = 6;
    localparam int unsigned SW  = 4;
    localparam int unsigned TW  = 2;
    localparam int unsigned RDW = 16 * DW;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           alloc_req;
    logic [RDW-1:0] snap_d;
    logic [SW-1:0]  snap_s;
    logic           alloc_gnt;
    logic [TW-1:0]  alloc_tag;
    logic           stall;
    logic           resolve_valid;
    logic [TW-1:0]  resolve_tag;
    logic           resolve_mispredict;
    logic           restore;
    logic [RDW-1:0] restore_d;
    logic [SW-1:0]  restore_s;
    logic [TW:0]    occupancy;
    logic           full;
    logic           empty;

    int total = 0;
    int bad   = 0;

    tt_checkpoint_ctrl dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .alloc_req          (alloc_req),
        .snap_d             (snap_d),
        .snap_s             (snap_s),
        .alloc_gnt          (alloc_gnt),
        .alloc_tag          (alloc_tag),
        .stall              (stall),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .restore            (restore),
        .restore_d          (restore_d),
        .restore_s          (restore_s),
        .occupancy          (occupancy),
        .full               (full),
        .empty              (empty)
    );

    always #5 clk = ~clk;

    function automatic logic [RDW-1:0] fill(input logic [DW-1:0] v);
        logic [RDW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    task automatic alloc_one(input logic [DW-1:0] dv, input logic [SW-1:0] sv,
                             input logic [TW-1:0] exp_tag, input string tag);
        alloc_req = 1'b1;
        snap_d    = fill(dv);
        snap_s    = sv;
        #1;
        chk({tag, "_gnt"}, alloc_gnt, 1'b1);
        chk({tag, "_tag"}, alloc_tag, exp_tag);
        tick();
        alloc_req = 1'b0;
    endtask

    task automatic resolve(input logic [TW-1:0] t, input logic misp);
        resolve_valid      = 1'b1;
        resolve_tag        = t;
        resolve_mispredict = misp;
    endtask

    task automatic resolve_off();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; alloc_req = 1'b0; snap_d = '0; snap_s = '0;
        resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        #1;
        chk("rst_occ", occupancy, 3'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_restore", restore, 1'b0);
        chk("rst_restore_d", restore_d, '0);
        chk("rst_restore_s", restore_s, 4'd0);

        // 1: first allocation
        alloc_one(6'd5, 4'd3, 2'd0, "t1_alloc0");
        chk("t1_occ", occupancy, 3'd1);
        chk("t1_empty", empty, 1'b0);

        // 2: fill, stall when full, grant with wrapped tag after retire
        alloc_one(6'd6, 4'd4, 2'd1, "t2_alloc1");
        alloc_one(6'd7, 4'd5, 2'd2, "t2_alloc2");
        alloc_one(6'd8, 4'd6, 2'd3, "t2_alloc3");
        alloc_req = 1'b1;
        resolve(2'd0, 1'b0);
        #1;
        chk("t2_full", full, 1'b1);
        chk("t2_occ_full", occupancy, 3'd4);
        chk("t2_stall", stall, 1'b1);
        chk("t2_gnt_blocked", alloc_gnt, 1'b0);
        tick();
        resolve_off();
        #1;
        chk("t2_gnt_blocked2", alloc_gnt, 1'b0);
        tick();
        chk("t2_gnt_wrap", alloc_gnt, 1'b1);
        chk("t2_tag_wrap", alloc_tag, 2'd0);
        tick();
        alloc_req = 1'b0;
        chk("t2_occ_after", occupancy, 3'd4);
        do_reset();

        // 3: mispredict tag 1 squashes 1 and 2, restores slot 1
        alloc_one(6'd1, 4'd1, 2'd0, "t3_alloc0");
        alloc_one(6'd2, 4'd2, 2'd1, "t3_alloc1");
        alloc_one(6'd3, 4'd3, 2'd2, "t3_alloc2");
        resolve(2'd1, 1'b1);
        tick();
        resolve_off();
        chk("t3_restore", restore, 1'b1);
        chk("t3_restore_s", restore_s, 4'd2);
        chk("t3_restore_d", restore_d, fill(6'd2));
        chk("t3_occ", occupancy, 3'd1);
        tick();
        chk("t3_restore_pulse", restore, 1'b0);
        chk("t3_restore_hold", restore_s, 4'd2);
        alloc_one(6'd4, 4'd4, 2'd1, "t3_realloc");

        // 4: out-of-order resolve, in-order retire
        resolve(2'd1, 1'b0);
        tick();
        resolve_off();
        chk("t4_occ_pending", occupancy, 3'd2);
        resolve(2'd0, 1'b0);
        tick();
        resolve_off();
        chk("t4_occ_done0", occupancy, 3'd2);
        tick();
        chk("t4_occ_ret0", occupancy, 3'd1);
        tick();
        chk("t4_occ_ret1", occupancy, 3'd0);
        chk("t4_empty", empty, 1'b1);
        do_reset();

        // 5: mispredict suppresses same-cycle alloc
        alloc_one(6'd9, 4'd7, 2'd0, "t5_alloc0");
        alloc_req = 1'b1;
        snap_d    = fill(6'd10);
        snap_s    = 4'd8;
        resolve(2'd0, 1'b1);
        #1;
        chk("t5_gnt", alloc_gnt, 1'b0);
        chk("t5_stall", stall, 1'b1);
        tick();
        resolve_off();
        #1;
        chk("t5_restore", restore, 1'b1);
        chk("t5_restore_s", restore_s, 4'd7);
        chk("t5_empty", empty, 1'b1);
        chk("t5_gnt_held", alloc_gnt, 1'b1);
        chk("t5_tag_held", alloc_tag, 2'd0);
        tick();
        alloc_req = 1'b0;
        chk("t5_restore_pulse", restore, 1'b0);
        chk("t5_occ", occupancy, 3'd1);

        // 6: non-live mispredict ignored; reset cancels pending restore
        resolve(2'd2, 1'b1);
        tick();
        resolve_off();
        chk("t6_nonlive_restore", restore, 1'b0);
        chk("t6_nonlive_occ", occupancy, 3'd1);
        resolve(2'd0, 1'b1);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        resolve_off();
        chk("t6_rst_restore", restore, 1'b0);
        chk("t6_rst_occ", occupancy, 3'd0);
        chk("t6_rst_empty", empty, 1'b1);
        chk("t6_rst_restore_s", restore_s, 4'd0);
        chk("t6_rst_restore_d", restore_d, '0);
        tick();
        chk("t6_no_late_restore", restore, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
